// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

   // Word offsets selected by address[3:2]
   localparam logic [1:0] RegTxData = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;
   localparam logic [1:0] RegCtrl   = 2'd2;
   localparam logic [1:0] RegRsvd   = 2'd3;

   localparam int unsigned StatusBusyBit  = 0;
   localparam int unsigned StatusFullBit  = 1;
   localparam int unsigned StatusEmptyBit = 2;
   localparam int unsigned StatusOvfBit   = 3;
   localparam int unsigned StatusCountLsb = 8;

   localparam int unsigned CtrlTxEnBit   = 0;
   localparam int unsigned CtrlIrqEnBit  = 1;
   localparam int unsigned CtrlOvfClrBit = 2;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core-side bus of the UART transmitter: strobes, address, store data and read return.
interface uart_tx_mmio_if;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        r_en;
   logic        w_en;
   logic        hit;
   logic [31:0] rd_data;

   modport master (output address, data_in, r_en, w_en, input hit, rd_data);
   modport slave  (input address, data_in, r_en, w_en, output hit, rd_data);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO succeeds only alongside a pop.
module uart_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW-1:0] PtrMask = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q + AW'(1)) & PtrMask;
         if (do_pop)  rd_ptr_q <= (rd_ptr_q + AW'(1)) & PtrMask;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, CTRL/overflow registers, baud counter, TX FSM.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic          clk_in,
   input  logic          rst_in,
   uart_tx_mmio_if.slave bus,
   output logic          tx,
   output logic          irq
);
   localparam int unsigned BW = $clog2(CLK_DIV);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d, irq_q, irq_d;
   logic          tx_en_q, irq_en_q, ovf_q;

   logic [1:0]    sel;
   logic          wr_hit, rd_hit, push, pop, ctrl_wr, baud_end, start_ok;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   rd_data;
   logic          unused_bits;

   assign bus.hit     = (bus.address[31:4] == BASE_ADDR[31:4]);
   assign sel         = bus.address[3:2];
   assign wr_hit      = bus.w_en && bus.hit;
   assign rd_hit      = bus.r_en && bus.hit;
   assign push        = wr_hit && (sel == RegTxData);
   assign ctrl_wr     = wr_hit && (sel == RegCtrl);
   assign baud_end    = (baud_q == BW'(CLK_DIV - 1));
   assign start_ok    = tx_en_q && !fifo_empty;
   assign irq_d       = irq_en_q && fifo_empty && (state_q == StIdle);
   assign tx          = tx_q;
   assign irq         = irq_q;
   assign bus.rd_data = rd_data;
   assign unused_bits = ^{bus.address[1:0], bus.data_in[31:8]};

   uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (push),
      .pop    (pop),
      .din    (bus.data_in[7:0]),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_ok) state_d = StStart;
         StStart: if (baud_end) state_d = StData;
         StData:  if (baud_end && bit_cnt_q == 3'd7) state_d = StStop;
         StStop:  if (baud_end) state_d = start_ok ? StStart : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // tx is registered from the next state so the line changes on the same edge as the state.
   always_comb begin
      pop       = 1'b0;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = (state_q == StIdle || baud_end) ? '0 : baud_q + BW'(1);
      if (state_d == StStart && (state_q == StIdle || state_q == StStop)) begin
         pop       = 1'b1;
         shreg_d   = fifo_dout;
         bit_cnt_d = '0;
      end
      if (state_q == StData && baud_end) begin
         shreg_d   = shreg_q >> 1;
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
         irq_q     <= 1'b0;
         tx_en_q   <= 1'b1;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
         if (ctrl_wr) begin
            tx_en_q  <= bus.data_in[CtrlTxEnBit];
            irq_en_q <= bus.data_in[CtrlIrqEnBit];
         end
         if (push && fifo_full && !pop)                  ovf_q <= 1'b1;
         else if (ctrl_wr && bus.data_in[CtrlOvfClrBit]) ovf_q <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_hit) begin
         case (sel)
            RegStatus: begin
               rd_data[StatusBusyBit]        = (state_q != StIdle);
               rd_data[StatusFullBit]        = fifo_full;
               rd_data[StatusEmptyBit]       = fifo_empty;
               rd_data[StatusOvfBit]         = ovf_q;
               rd_data[StatusCountLsb +: 8]  = 8'(fifo_count);
            end
            RegCtrl: begin
               rd_data[CtrlTxEnBit]  = tx_en_q;
               rd_data[CtrlIrqEnBit] = irq_en_q;
            end
            default: rd_data = '0;
         endcase
      end
   end

endmodule
